// File: rtl/approx_mult_pkg.sv
`default_nettype none
// ============================================================================
// Package  : approx_mult_pkg
// Purpose  : Shared definitions for the split-operand approximate multiplier.
//            Approximation mode encodings and the truncation-mask helper.
// Revision : 1.0 - initial release
// ============================================================================
package approx_mult_pkg;

  // Approximation mode encodings (bit0 -> LL approx, bit1 -> LH/HL approx)
  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_LL    = 2'b01;
  localparam logic [1:0] MODE_MID   = 2'b10;
  localparam logic [1:0] MODE_ALL   = 2'b11;

  // Mask with the low 'trunc' bits cleared and all others set. Callers take
  // the low slice they need; sub-products up to 64 bits are covered.
  function automatic logic [63:0] trunc_mask(input int trunc);
    trunc_mask = ~((64'd1 << trunc) - 64'd1);
  endfunction

endpackage : approx_mult_pkg
`default_nettype wire

// File: rtl/trunc_sub_mult.sv
`default_nettype none
// ============================================================================
// Module   : trunc_sub_mult
// Purpose  : Combinational H x H unsigned multiplier whose product can have
//            its low TRUNC bits cleared on request.
// Ports    : a, b   - H-bit unsigned operands
//            approx - 1 clears product bits [TRUNC-1:0]
//            p      - 2H-bit product
// Revision : 1.0 - initial release
// ============================================================================
module trunc_sub_mult
  import approx_mult_pkg::*;
#(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  input  logic           approx,
  output logic [2*H-1:0] p
);

  localparam int              c_PW        = 2 * H;
  localparam logic [63:0]     c_MASK_FULL = trunc_mask(TRUNC);
  localparam logic [c_PW-1:0] c_MASK      = c_MASK_FULL[c_PW-1:0];

  logic [c_PW-1:0] w_exact;

  // Operands widened first so the product keeps all 2H bits.
  assign w_exact = c_PW'(a) * c_PW'(b);
  assign p       = approx ? (w_exact & c_MASK) : w_exact;

endmodule : trunc_sub_mult
`default_nettype wire

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_mult_pipe
// Purpose  : Three-stage pipelined split-operand multiplier with per-request
//            approximation of the LL and LH/HL sub-products, valid/ready flow
//            control, pass-through tag and saturating completion counter.
// Ports    : clk, rst_n                - clock, async active-low reset
//            in_valid/in_ready         - request handshake
//            in_a, in_b                - WIDTH-bit unsigned operands
//            in_mode                   - approximation mode
//            in_tag                    - user tag, returned with result
//            out_valid/out_ready       - result handshake
//            out_p, out_tag            - product and its tag
//            op_count                  - completed result handshakes
// Revision : 1.0 - initial release
// ============================================================================
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic [CNT_W-1:0]   op_count
);

  localparam int c_H  = WIDTH / 2;
  localparam int c_PW = 2 * c_H;
  localparam int c_SW = 2 * WIDTH + 1;

  // Global advance: every stage moves together or holds together.
  logic w_adv;

  // Stage 1: operands, mode, tag
  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic [1:0]         r_s1_mode;
  logic [TAG_W-1:0]   r_s1_tag;

  // Stage 2: sub-products
  logic               r_s2_valid;
  logic [c_PW-1:0]    r_s2_hh;
  logic [c_PW-1:0]    r_s2_hl;
  logic [c_PW-1:0]    r_s2_lh;
  logic [c_PW-1:0]    r_s2_ll;
  logic [TAG_W-1:0]   r_s2_tag;

  // Stage 3: final result
  logic               r_s3_valid;
  logic [2*WIDTH-1:0] r_s3_p;
  logic [TAG_W-1:0]   r_s3_tag;
  logic [CNT_W-1:0]   r_count;

  logic               w_ll_approx;
  logic               w_mid_approx;
  logic [c_PW-1:0]    w_hh;
  logic [c_PW-1:0]    w_hl;
  logic [c_PW-1:0]    w_lh;
  logic [c_PW-1:0]    w_ll;
  logic [c_SW-1:0]    w_sum;

  assign w_adv    = !r_s3_valid || out_ready;
  assign in_ready = w_adv;

  assign w_ll_approx  = (r_s1_mode == MODE_LL)  || (r_s1_mode == MODE_ALL);
  assign w_mid_approx = (r_s1_mode == MODE_MID) || (r_s1_mode == MODE_ALL);

  trunc_sub_mult #(.H(c_H), .TRUNC(TRUNC)) u_hh (
    .a      (r_s1_a[WIDTH-1:c_H]),
    .b      (r_s1_b[WIDTH-1:c_H]),
    .approx (1'b0),
    .p      (w_hh)
  );

  trunc_sub_mult #(.H(c_H), .TRUNC(TRUNC)) u_hl (
    .a      (r_s1_a[WIDTH-1:c_H]),
    .b      (r_s1_b[c_H-1:0]),
    .approx (w_mid_approx),
    .p      (w_hl)
  );

  trunc_sub_mult #(.H(c_H), .TRUNC(TRUNC)) u_lh (
    .a      (r_s1_a[c_H-1:0]),
    .b      (r_s1_b[WIDTH-1:c_H]),
    .approx (w_mid_approx),
    .p      (w_lh)
  );

  trunc_sub_mult #(.H(c_H), .TRUNC(TRUNC)) u_ll (
    .a      (r_s1_a[c_H-1:0]),
    .b      (r_s1_b[c_H-1:0]),
    .approx (w_ll_approx),
    .p      (w_ll)
  );

  // Summed one bit wider than the result; the top bit is provably zero.
  assign w_sum = (c_SW'(r_s2_hh) << WIDTH)
               + ((c_SW'(r_s2_hl) + c_SW'(r_s2_lh)) << c_H)
               + c_SW'(r_s2_ll);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= MODE_EXACT;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_hh    <= '0;
      r_s2_hl    <= '0;
      r_s2_lh    <= '0;
      r_s2_ll    <= '0;
      r_s2_tag   <= '0;
      r_s3_valid <= 1'b0;
      r_s3_p     <= '0;
      r_s3_tag   <= '0;
    end else if (w_adv) begin
      // Bubbles travel like data: data registers load regardless of valid.
      r_s1_valid <= in_valid;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_mode  <= in_mode;
      r_s1_tag   <= in_tag;
      r_s2_valid <= r_s1_valid;
      r_s2_hh    <= w_hh;
      r_s2_hl    <= w_hl;
      r_s2_lh    <= w_lh;
      r_s2_ll    <= w_ll;
      r_s2_tag   <= r_s1_tag;
      r_s3_valid <= r_s2_valid;
      r_s3_p     <= (2*WIDTH)'(w_sum);
      r_s3_tag   <= r_s2_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_s3_valid && out_ready && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign out_valid = r_s3_valid;
  assign out_p     = r_s3_p;
  assign out_tag   = r_s3_tag;
  assign op_count  = r_count;

endmodule : approx_mult_pipe
`default_nettype wire

// File: tb/tb_approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_mult_pipe
// Purpose  : Self-checking bench. Three instances share one handshake:
//            8-bit/TRUNC=2 (main), 16-bit/TRUNC=0 (exact check) and
//            8-bit with a 4-bit counter (saturation check).
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        in_ready, out_valid;
  logic [15:0] out_p;
  logic [3:0]  out_tag;
  logic [15:0] op_count;

  logic [15:0] wa, wb;
  logic [1:0]  wmode;
  logic [3:0]  wtag;
  logic        w_in_ready, w_out_valid;
  logic [31:0] w_out_p;
  logic [3:0]  w_out_tag;
  logic [15:0] w_op_count;

  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_p;
  logic [3:0]  s_out_tag;
  logic [3:0]  s_op_count;

  always #5 clk = ~clk;

  approx_mult_pipe #(.WIDTH(8), .TRUNC(2), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_tag(out_tag), .op_count(op_count)
  );

  approx_mult_pipe #(.WIDTH(16), .TRUNC(0), .TAG_W(4), .CNT_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(wa), .in_b(wb), .in_mode(wmode), .in_tag(wtag),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_p(w_out_p),
    .out_tag(w_out_tag), .op_count(w_op_count)
  );

  approx_mult_pipe #(.WIDTH(8), .TRUNC(2), .TAG_W(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_p(s_out_p),
    .out_tag(s_out_tag), .op_count(s_op_count)
  );

  // --------------------------------------------------------------------------
  // Reference model: split-operand arithmetic straight from the definition.
  // --------------------------------------------------------------------------
  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] m);
    int ah, al, bh, bl, hh, hl, lh, ll;
    ah = int'(a) / 16;  al = int'(a) % 16;
    bh = int'(b) / 16;  bl = int'(b) % 16;
    hh = ah * bh;  hl = ah * bl;  lh = al * bh;  ll = al * bl;
    if (m[0]) ll = ll - (ll % 4);
    if (m[1]) begin
      hl = hl - (hl % 4);
      lh = lh - (lh % 4);
    end
    return 16'(hh * 256 + (hl + lh) * 16 + ll);
  endfunction

  typedef struct {
    logic [15:0] p;
    logic [3:0]  tag;
    logic [31:0] pw;
    logic [3:0]  tagw;
    int          t;
    logic        lit_v;
    logic [15:0] lit_p;
  } item_t;

  item_t       q[$];
  item_t       it;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cnt;
  int          advs;
  logic        exp_ov, adv, prev_stall;
  logic [15:0] prev_p;
  logic [3:0]  prev_tag;

  // Stimulus-to-checker side channel
  logic        lit_v = 1'b0;
  logic [15:0] lit_p = '0;
  logic        cnt_lit_v = 1'b0;
  int          cnt_lit = 0;
  int          sat_lit = 0;
  logic        to_flag = 1'b0;
  logic        done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Checker: sampled on the falling edge, tracks accepted requests in a queue
  // tagged with the advance count at which they entered.
  // --------------------------------------------------------------------------
  initial begin
    check("pin_mode0", 32'(model8(8'hFF, 8'hFF, 2'd0)), 32'hFE01);
    check("pin_mode1", 32'(model8(8'hFF, 8'hFF, 2'd1)), 32'hFE00);
    check("pin_mode2", 32'(model8(8'hFF, 8'hFF, 2'd2)), 32'hFDE1);
    check("pin_mode3", 32'(model8(8'hFF, 8'hFF, 2'd3)), 32'hFDE0);
    check("pin_zero",  32'(model8(8'h00, 8'hFF, 2'd3)), 32'h0000);
    check("pin_mix",   32'(model8(8'h12, 8'h34, 2'd0)), 32'h03A8);
    cnt = 0; advs = 0; prev_stall = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_p", 32'(out_p), 0);
        check("rst_out_tag", 32'(out_tag), 0);
        check("rst_op_count", 32'(op_count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_w_valid", 32'(w_out_valid), 0);
        check("rst_s_count", 32'(s_op_count), 0);
        q.delete();
        cnt = 0;
        prev_stall = 1'b0;
      end else begin
        exp_ov = (q.size() > 0) && ((advs - q[0].t) >= 2);
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("w_out_valid", 32'(w_out_valid), 32'(exp_ov));
        check("s_out_valid", 32'(s_out_valid), 32'(exp_ov));
        if (exp_ov) begin
          check("out_p", 32'(out_p), 32'(q[0].p));
          check("out_tag", 32'(out_tag), 32'(q[0].tag));
          check("w_out_p", w_out_p, q[0].pw);
          check("w_out_tag", 32'(w_out_tag), 32'(q[0].tagw));
          check("s_out_p", 32'(s_out_p), 32'(q[0].p));
          if (q[0].lit_v) check("out_p_literal", 32'(out_p), 32'(q[0].lit_p));
        end
        check("in_ready", 32'(in_ready), 32'(!exp_ov || out_ready));
        check("w_in_ready", 32'(w_in_ready), 32'(!exp_ov || out_ready));
        check("s_in_ready", 32'(s_in_ready), 32'(!exp_ov || out_ready));
        check("op_count", 32'(op_count), 32'(cnt));
        check("w_op_count", 32'(w_op_count), 32'(cnt));
        check("s_op_count", 32'(s_op_count), 32'((cnt > 15) ? 15 : cnt));
        if (cnt_lit_v) begin
          check("op_count_literal", 32'(op_count), 32'(cnt_lit));
          check("s_op_count_sat", 32'(s_op_count), 32'(sat_lit));
        end
        if (prev_stall && out_valid) begin
          check("stall_hold_p", 32'(out_p), 32'(prev_p));
          check("stall_hold_tag", 32'(out_tag), 32'(prev_tag));
        end
        prev_stall = out_valid && !out_ready;
        prev_p     = out_p;
        prev_tag   = out_tag;
        adv = !exp_ov || out_ready;
        if (adv) begin
          if (exp_ov) begin
            void'(q.pop_front());
            cnt++;
          end
          advs++;
          if (in_valid) begin
            it.p     = model8(in_a, in_b, in_mode);
            it.tag   = in_tag;
            it.pw    = 32'(wa) * 32'(wb);
            it.tagw  = wtag;
            it.t     = advs;
            it.lit_v = lit_v;
            it.lit_p = lit_p;
            q.push_back(it);
          end
        end
      end
    end
    check("no_timeout", 32'(to_flag), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // --------------------------------------------------------------------------
  // Stimulus: inputs change 2 time units after the rising edge.
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                      input logic [3:0] t, input logic lv, input logic [15:0] lp);
    int   guard;
    logic acc;
    in_valid = 1'b1;
    in_a = a;  in_b = b;  in_mode = m;  in_tag = t;
    lit_v = lv;  lit_p = lp;
    wa = 16'($urandom);  wb = 16'($urandom);
    wmode = 2'($urandom);  wtag = 4'($urandom);
    guard = 0;
    do begin
      acc = in_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) to_flag = 1'b1;
    in_valid = 1'b0;
    lit_v = 1'b0;
  endtask

  task automatic send_rand();
    send(8'($urandom), 8'($urandom), 2'($urandom), 4'($urandom), 1'b0, 16'h0);
  endtask

  task automatic drain();
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 40) begin
      tick();
      guard++;
    end
    if (q.size() != 0) to_flag = 1'b1;
    tick();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;  out_ready = 1'b1;
    in_a = '0;  in_b = '0;  in_mode = '0;  in_tag = '0;
    wa = '0;  wb = '0;  wmode = '0;  wtag = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed mode vectors, back to back
    send(8'hFF, 8'hFF, 2'd0, 4'd3, 1'b1, 16'hFE01);
    send(8'hFF, 8'hFF, 2'd1, 4'd1, 1'b1, 16'hFE00);
    send(8'hFF, 8'hFF, 2'd2, 4'd2, 1'b1, 16'hFDE1);
    send(8'hFF, 8'hFF, 2'd3, 4'd5, 1'b1, 16'hFDE0);
    send(8'h00, 8'hFF, 2'd3, 4'd6, 1'b1, 16'h0000);
    send(8'h12, 8'h34, 2'd0, 4'd7, 1'b1, 16'h03A8);
    drain();

    // Streaming: 100 back-to-back requests from a clean count
    do_reset(2);
    for (int i = 0; i < 100; i++) send_rand();
    drain();
    cnt_lit = 100;  sat_lit = 15;  cnt_lit_v = 1'b1;
    tick();
    cnt_lit_v = 1'b0;

    // Backpressure with a 5-cycle stall while results are pending
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          out_ready = (i >= 4 && i < 9) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 20; i++) begin
          if (i > 4 && $urandom_range(0, 3) == 0) tick();
          send_rand();
        end
      end
    join
    drain();

    // Reset with three requests in flight
    for (int i = 0; i < 3; i++) send_rand();
    do_reset(2);
    repeat (5) tick();
    for (int i = 0; i < 4; i++) send_rand();
    drain();
    cnt_lit = 4;  sat_lit = 4;  cnt_lit_v = 1'b1;
    tick();
    cnt_lit_v = 1'b0;

    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_approx_mult_pipe
`default_nettype wire
